// File: rtl/lsqCamPkg.sv
// Shared definitions for the partitioned LSQ CAM: compare-function encodings
// and the clear-engine state type.
package lsqCamPkg;

  localparam int CAM_EQ = 0;
  localparam int CAM_GT = 1;
  localparam int CAM_LT = 2;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ALL,
    CLEAR_PART
  } camClrState_t;

endpackage

// File: rtl/lsq_cam_partitioned_clear_fsm.sv
// Sequential clear engine: sweeps the whole array after reset and single
// partitions after they are deactivated, one entry per cycle.
module lsq_cam_clear_fsm
  import lsqCamPkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int INDEX     = 5,
  parameter int NUM_PARTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PARTS-1:0] partActive_i,
  output logic                 clrEn_o,
  output logic [INDEX-1:0]     clrIdx_o,
  output logic                 ready_o
);

  localparam int PW = $clog2(NUM_PARTS);
  localparam int OW = INDEX - PW;

  camClrState_t         state_q, state_d;
  logic [INDEX-1:0]     ptr_q, ptr_d;
  logic [NUM_PARTS-1:0] pend_q, pend_d;
  logic [NUM_PARTS-1:0] partPrev_q;
  logic [NUM_PARTS-1:0] fall;
  logic [NUM_PARTS-1:0] curMask;

  function automatic logic [PW-1:0] lowest(input logic [NUM_PARTS-1:0] m);
    logic [PW-1:0] r;
    r = '0;
    for (int k = NUM_PARTS - 1; k >= 0; k--) begin
      if (m[k]) r = PW'(k);
    end
    return r;
  endfunction

  assign fall     = partPrev_q & ~partActive_i;
  assign clrIdx_o = ptr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    clrEn_o = 1'b0;
    ready_o = 1'b0;
    curMask = '0;
    curMask[ptr_q[INDEX-1 -: PW]] = 1'b1;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (|fall) begin
          state_d = CLEAR_PART;
          pend_d  = fall;
          ptr_d   = {lowest(fall), {OW{1'b0}}};
        end
      end
      CLEAR_ALL: begin
        clrEn_o = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      CLEAR_PART: begin
        clrEn_o = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        pend_d  = pend_q | fall;
        // A partition that falls again while being swept stays pending.
        if (&ptr_q[OW-1:0]) begin
          pend_d = (pend_q & ~curMask) | fall;
          if (pend_d == '0) state_d = IDLE;
          else              ptr_d   = {lowest(pend_d), {OW{1'b0}}};
        end
      end
      default: begin
        state_d = CLEAR_ALL;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CLEAR_ALL;
      ptr_q      <= '0;
      pend_q     <= '0;
      partPrev_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      partPrev_q <= partActive_i;
    end
  end

endmodule

// File: rtl/lsq_cam_partitioned.sv
// Multi-port partitioned CAM for the load/store queue: tag/valid storage,
// write/invalidate priority, compare network and indexed reads.
module lsq_cam_partitioned
  import lsqCamPkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int INDEX     = 5,
  parameter int WIDTH     = 8,
  parameter int NUM_WR    = 2,
  parameter int NUM_INV   = 2,
  parameter int NUM_CAM   = 2,
  parameter int NUM_RD    = 1,
  parameter int NUM_PARTS = 4,
  parameter int FUNCTION  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PARTS-1:0]       partActive_i,
  input  logic [NUM_WR-1:0]          we_i,
  input  logic [NUM_WR*INDEX-1:0]    wrAddr_i,
  input  logic [NUM_WR*WIDTH-1:0]    wrData_i,
  input  logic [NUM_INV-1:0]         inv_i,
  input  logic [NUM_INV*INDEX-1:0]   invAddr_i,
  input  logic [NUM_CAM-1:0]         camEn_i,
  input  logic [NUM_CAM*WIDTH-1:0]   tag_i,
  output logic [NUM_CAM*DEPTH-1:0]   vect_o,
  input  logic [NUM_RD*INDEX-1:0]    rdAddr_i,
  output logic [NUM_RD*WIDTH-1:0]    data_o,
  output logic [NUM_RD-1:0]          valid_o,
  output logic                       ready_o
);

  localparam int PSIZE = DEPTH / NUM_PARTS;
  localparam int PW    = $clog2(NUM_PARTS);

  logic             clrEn;
  logic [INDEX-1:0] clrIdx;
  logic             ready;
  logic [WIDTH-1:0] entryTag [DEPTH];
  logic [DEPTH-1:0] entryValid;

  lsq_cam_clear_fsm #(
    .DEPTH     (DEPTH),
    .INDEX     (INDEX),
    .NUM_PARTS (NUM_PARTS)
  ) u_clear_fsm (
    .clk          (clk),
    .reset        (reset),
    .partActive_i (partActive_i),
    .clrEn_o      (clrEn),
    .clrIdx_o     (clrIdx),
    .ready_o      (ready)
  );

  assign ready_o = ready;

  function automatic logic cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (FUNCTION)
      CAM_GT:  return a > b;
      CAM_LT:  return a < b;
      default: return a == b;
    endcase
  endfunction

  genvar gi, gj;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] tag_q, tag_d;
      logic             valid_q, valid_d;

      // Sweep beats everything; otherwise invalidates first so writes win.
      always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        if (clrEn && clrIdx == INDEX'(gi)) begin
          tag_d   = '0;
          valid_d = 1'b0;
        end else if (ready && partActive_i[gi/PSIZE]) begin
          for (int k = 0; k < NUM_INV; k++) begin
            if (inv_i[k] && invAddr_i[k*INDEX +: INDEX] == INDEX'(gi)) valid_d = 1'b0;
          end
          for (int k = 0; k < NUM_WR; k++) begin
            if (we_i[k] && wrAddr_i[k*INDEX +: INDEX] == INDEX'(gi)) begin
              tag_d   = wrData_i[k*WIDTH +: WIDTH];
              valid_d = 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) valid_q <= 1'b0;
        else        valid_q <= valid_d;
      end

      always_ff @(posedge clk) begin
        tag_q <= tag_d;
      end

      assign entryTag[gi]   = tag_q;
      assign entryValid[gi] = valid_q;

      for (gj = 0; gj < NUM_CAM; gj++) begin : g_cam
        assign vect_o[gj*DEPTH + gi] = camEn_i[gj] & entryValid[gi] &
                                       partActive_i[gi/PSIZE] & ready &
                                       cmp(entryTag[gi], tag_i[gj*WIDTH +: WIDTH]);
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [INDEX-1:0] addr;
      logic             live;
      assign addr = rdAddr_i[gi*INDEX +: INDEX];
      assign live = ready & partActive_i[addr[INDEX-1 -: PW]];
      assign data_o[gi*WIDTH +: WIDTH] = live ? entryTag[addr] : '0;
      assign valid_o[gi]               = live & entryValid[addr];
    end
  endgenerate

endmodule

// File: doc/lsq_cam_partitioned.md
# lsq_cam_partitioned

Parametrised multi-port CAM for the load/store queue, successor to the single-search, two-write store-queue CAM. Adds per-entry valid bits, multiple search and read ports, selectable compare function, per-entry invalidate ports, partition gating, and a sequential clear engine that drives `ready_o`. Sits between LSQ allocation/commit logic (writers) and the load/store disambiguation logic (searchers).

## Interface

**Parameters**

- `DEPTH`, 32: number of entries; a multiple of `NUM_PARTS`.
- `INDEX`, 5: entry index width, log2(DEPTH).
- `WIDTH`, 8: tag width.
- `NUM_WR`, 2: write ports.
- `NUM_INV`, 2: invalidate ports.
- `NUM_CAM`, 2: search ports.
- `NUM_RD`, 1: indexed read ports.
- `NUM_PARTS`, 4: partitions, each DEPTH/NUM_PARTS contiguous entries.
- `FUNCTION`, 0: compare function. 0 is entry == tag, 1 is entry > tag, 2 is entry < tag. All compares are unsigned.

**Ports**

- `clk`  in  1  clock.
- `reset`  in  1  reset; one clock; asynchronous, active-low.
- `partActive_i`  in  NUM_PARTS  per-partition enable; 1 = active.
- `we_i`  in  NUM_WR  write enables.
- `wrAddr_i`  in  NUM_WR×INDEX  write indices.
- `wrData_i`  in  NUM_WR×WIDTH  write tags; a write sets the entry's valid bit.
- `inv_i`  in  NUM_INV  invalidate enables.
- `invAddr_i`  in  NUM_INV×INDEX  invalidate indices.
- `camEn_i`  in  NUM_CAM  search enables.
- `tag_i`  in  NUM_CAM×WIDTH  search tags.
- `vect_o`  out  NUM_CAM×DEPTH  match vectors.
- `rdAddr_i`  in  NUM_RD×INDEX  read indices.
- `data_o`  out  NUM_RD×WIDTH  read data.
- `valid_o`  out  NUM_RD  valid bit of the entry being read.
- `ready_o`  out  1  high when no clear is in progress.

## Operation

- **Reset asserted**
  - All valid bits are cleared asynchronously.
  - The FSM enters CLEAR_ALL with the sweep pointer at 0.
  - `ready_o` is 0.
  - The tag array is not reset directly; the sweep clears it.
- **FSM states**
  - IDLE, CLEAR_ALL, CLEAR_PART.
  - **CLEAR_ALL:** one entry per cycle is set to tag 0 and valid 0, in ascending order from 0. After entry DEPTH-1 the FSM goes to IDLE.
  - **IDLE to CLEAR_PART:** taken when any `partActive_i` bit falls from 1 to 0 (compared against a registered copy). The pending-clear mask records every partition that fell.
  - **CLEAR_PART:** sweeps the entries of the lowest pending partition, one per cycle. When that partition is done, its pending bit is cleared and the FSM moves to the next pending partition. When the mask is empty it returns to IDLE.
  - Partitions that fall during CLEAR_PART are added to the mask.
  - In CLEAR_ALL, falling edges are ignored, since the whole array is being cleared.
  - A partition going from 0 to 1 causes no sweep.
- **`ready_o`** is 1 only in IDLE.
- **While `ready_o` = 0**
  - Writes and invalidates are dropped.
  - `vect_o` is all 0.
  - `data_o` and `valid_o` are 0.
- **Partition gating.** In an inactive partition:
  - writes and invalidates are dropped;
  - its `vect_o` bits are 0;
  - reads return 0 data and valid 0.
- **Search.** For each port, `vect_o[p][i]` = `camEn_i[p]` & valid[i] & partActive[i] & ready & cmp(ram[i], `tag_i[p]`).
- **Collision priority**
  - Two writes to the same index: the highest-numbered write port wins.
  - Write and invalidate to the same index in the same cycle: the write wins, and the entry ends with valid = 1.
  - Duplicate invalidates are harmless.

## Timing

- Writes and invalidates are registered and become visible to search and read on the next cycle. There is no same-cycle bypass.
- Search and read are combinational from the registered state.
- **Clear durations**
  - CLEAR_ALL lasts exactly DEPTH cycles from the first rising clock after `reset` deasserts.
  - CLEAR_PART lasts DEPTH/NUM_PARTS cycles per pending partition.
  - A falling `partActive_i` edge sampled at edge N drops `ready_o` at N+1.
- **Reset asserted mid-sweep** aborts the sweep immediately. The sweep then restarts from entry 0 after reset deasserts.

## Structure

- **Shared package `lsqCamPkg`**
  - holds the FUNCTION encodings `CAM_EQ`, `CAM_GT`, `CAM_LT`;
  - holds the FSM state enum `camClrState_t`.
- **Sub-module `lsq_cam_clear_fsm`** contains:
  - the state register, sweep pointer and pending-clear mask;
  - the registered `partActive` copy;
  - outputs for clear-enable, clear-index and `ready_o`.
- **Top level** holds the tag/valid arrays, the write/invalidate priority logic and the compare network.

## Test plan

- **Reset release**, DEPTH=32: `ready_o` = 0 for exactly 32 cycles, then 1. Every `valid_o` read is 0, and searching tag 0 returns vect 0.
- **Write collision:** write port 0 writes 0x11 and port 1 writes 0x22 to index 5 in the same cycle. The next cycle, read of index 5 gives 0x22 with valid 1; an EQ search for 0x22 returns bit 5 only; a search for 0x11 returns 0.
- **Write vs invalidate:** a write of 0x33 to index 7 and an invalidate of index 7 in the same cycle. Result is valid 1 with data 0x33. An invalidate alone on the next cycle gives vect bit 7 = 0.
- **GT mode:** FUNCTION=1, entries 0..3 hold 0x10, 0x20, 0x30, 0x05, search tag 0x18. Expect vect = 0b0110 over entries 0..3; invalid entries never match.
- **Partition deactivate:** all entries are valid and partition 2 is dropped. Then:
  - `ready_o` = 0 for exactly 8 cycles (DEPTH=32, NUM_PARTS=4), then 1;
  - entries 16..23 read valid 0;
  - other partitions are unchanged;
  - writes issued during the sweep are dropped.
- **Reset mid-sweep:** assert `reset` at sweep index 10. Outputs go inactive immediately. After release, the sweep takes a full 32 cycles.
